// File: rtl/seven_segment_scan_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_segment_scan_controller_pkg
//  Description : Shared constants and timing helper for the seven-segment
//                scan controller (segment patterns, sub-phase count, slot /
//                sub-phase / blink period derivation).
//  Revision    : 1.0 - initial release
// ============================================================================
package seven_segment_scan_controller_pkg;

    // Number of brightness sub-phases per slot (16-level PWM)
    localparam int c_SUB_PHASES = 16;

    // Active-high segment patterns, bit0 = a ... bit6 = g
    localparam logic [6:0] c_SEG_0     = 7'h3F;
    localparam logic [6:0] c_SEG_1     = 7'h06;
    localparam logic [6:0] c_SEG_2     = 7'h5B;
    localparam logic [6:0] c_SEG_3     = 7'h4F;
    localparam logic [6:0] c_SEG_4     = 7'h66;
    localparam logic [6:0] c_SEG_5     = 7'h6D;
    localparam logic [6:0] c_SEG_6     = 7'h7D;
    localparam logic [6:0] c_SEG_7     = 7'h07;
    localparam logic [6:0] c_SEG_8     = 7'h7F;
    localparam logic [6:0] c_SEG_9     = 7'h6F;
    localparam logic [6:0] c_SEG_DASH  = 7'h40;
    localparam logic [6:0] c_SEG_BLANK = 7'h00;

    // Derived scan timing; ok is cleared when the parameter set is unusable
    typedef struct packed {
        logic [31:0] ticks;
        logic [31:0] sub;
        logic [31:0] hb;
        logic        ok;
    } scan_timing_t;

    // Slot length, sub-phase length and blink half-period from the clock rates
    function automatic scan_timing_t calc_scan_timing(
        input int clk_in,
        input int refresh_hz,
        input int blink_hz,
        input int digit_num
    );
        scan_timing_t t;
        t = '0;
        if ((refresh_hz > 0) && (blink_hz > 0) && (clk_in > 0)) begin
            t.ticks = 32'(clk_in / refresh_hz);
            t.sub   = 32'((clk_in / refresh_hz) / c_SUB_PHASES);
            t.hb    = 32'(clk_in / (2 * blink_hz));
        end
        t.ok = (digit_num >= 1) && (digit_num <= 8) &&
               (t.ticks >= 32'(c_SUB_PHASES)) && (t.hb >= 32'd1);
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_segment_scan_controller_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : seven_segment_encoder
//  Description : Combinational BCD nibble to 7-segment pattern (active-high).
//                Values 10-15 render as a dash.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_encoder
    import seven_segment_scan_controller_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_pattern
);

    // Nibble lookup; anything outside 0-9 shows a dash
    always_comb begin
        o_pattern = c_SEG_DASH;
        case (i_nibble)
            4'd0:    o_pattern = c_SEG_0;
            4'd1:    o_pattern = c_SEG_1;
            4'd2:    o_pattern = c_SEG_2;
            4'd3:    o_pattern = c_SEG_3;
            4'd4:    o_pattern = c_SEG_4;
            4'd5:    o_pattern = c_SEG_5;
            4'd6:    o_pattern = c_SEG_6;
            4'd7:    o_pattern = c_SEG_7;
            4'd8:    o_pattern = c_SEG_8;
            4'd9:    o_pattern = c_SEG_9;
            default: o_pattern = c_SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seven_segment_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : seven_segment_scan_controller
//  Description : Time-multiplexed BCD display driver with per-digit DP and
//                blink, leading-zero suppression, 16-level PWM brightness and
//                configurable pin polarity. Single clock, clock-enable scan.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_scan_controller
    import seven_segment_scan_controller_pkg::*;
#(
    parameter int CLK_IN         = 100_000_000,
    parameter int DIGIT_NUM      = 4,
    parameter int REFRESH_HZ     = 500,
    parameter int BLINK_HZ       = 2,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int ACTIVE_LOW_AN  = 1
)(
    input  logic                   i_Clk,
    input  logic                   i_Reset_n,
    input  logic                   i_Enable,
    input  logic [4*DIGIT_NUM-1:0] i_BCD_Num,
    input  logic [DIGIT_NUM-1:0]   i_DP,
    input  logic [DIGIT_NUM-1:0]   i_Blink_Mask,
    input  logic                   i_Blank_Zeros,
    input  logic [3:0]             i_Brightness,
    output logic [6:0]             o_Segments,
    output logic                   o_DP,
    output logic [DIGIT_NUM-1:0]   o_Anodes,
    output logic                   o_Frame_Start
);

    localparam scan_timing_t c_TIMING = calc_scan_timing(CLK_IN, REFRESH_HZ, BLINK_HZ, DIGIT_NUM);
    localparam int c_TICKS   = int'(c_TIMING.ticks);
    localparam int c_SUB     = int'(c_TIMING.sub);
    localparam int c_HB      = int'(c_TIMING.hb);
    localparam int c_SLOT_W  = (c_TICKS > 1) ? $clog2(c_TICKS) : 1;
    localparam int c_SUB_W   = (c_SUB   > 1) ? $clog2(c_SUB)   : 1;
    localparam int c_BLINK_W = (c_HB    > 1) ? $clog2(c_HB)    : 1;
    localparam int c_IDX_W   = (DIGIT_NUM > 1) ? $clog2(DIGIT_NUM) : 1;

    localparam logic [3:0]           c_PHASE_MAX = 4'(c_SUB_PHASES - 1);
    localparam logic [DIGIT_NUM-1:0] c_AN_OFF    = (ACTIVE_LOW_AN  != 0) ? {DIGIT_NUM{1'b1}} : '0;
    localparam logic [6:0]           c_SEG_OFF   = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
    localparam logic                 c_DP_OFF    = (ACTIVE_LOW_SEG != 0);

    // Reject unusable parameter sets at elaboration
    if (!c_TIMING.ok) begin : g_param_check
        $error("seven_segment_scan_controller: DIGIT_NUM must be 1..8 and CLK_IN/REFRESH_HZ >= 16");
    end

    logic [c_SLOT_W-1:0]  r_slot_cnt;
    logic [c_SUB_W-1:0]   r_sub_cnt;
    logic [3:0]           r_phase;
    logic [c_IDX_W-1:0]   r_digit;       // digit the next slot will show
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_blink_on;

    logic                 r_slot_valid;  // cleared until the first slot after reset
    logic [c_IDX_W-1:0]   r_cur_digit;
    logic [3:0]           r_lat_nibble;
    logic                 r_lat_dp;
    logic                 r_lat_blink_off;
    logic                 r_lat_suppress;

    logic                 w_slot_wrap;
    logic                 w_sub_wrap;
    logic                 w_blink_wrap;
    logic                 w_blink_on_next;
    logic [3:0]           w_sel_nibble;
    logic                 w_sel_dp;
    logic                 w_sel_blink;
    logic                 w_sel_upper_zero;
    logic                 w_suppress;
    logic [6:0]           w_pattern;
    logic [6:0]           w_seg;
    logic                 w_dp;
    logic                 w_an_on;
    logic [DIGIT_NUM-1:0] w_an;

    assign w_slot_wrap     = (r_slot_cnt  == c_SLOT_W'(c_TICKS - 1));
    assign w_sub_wrap      = (r_sub_cnt   == c_SUB_W'(c_SUB - 1));
    assign w_blink_wrap    = (r_blink_cnt == c_BLINK_W'(c_HB - 1));
    assign w_blink_on_next = w_blink_wrap ? ~r_blink_on : r_blink_on;

    // Slot, sub-phase and digit-index sequencing
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_slot_cnt <= '0;
            r_sub_cnt  <= '0;
            r_phase    <= '0;
            r_digit    <= '0;
        end else if (w_slot_wrap) begin
            r_slot_cnt <= '0;
            r_sub_cnt  <= '0;
            r_phase    <= '0;
            r_digit    <= (r_digit == c_IDX_W'(DIGIT_NUM - 1)) ? '0 : r_digit + 1'b1;
        end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
            if (w_sub_wrap) begin
                r_sub_cnt <= '0;
                if (r_phase != c_PHASE_MAX) begin
                    r_phase <= r_phase + 1'b1;
                end
            end else begin
                r_sub_cnt <= r_sub_cnt + 1'b1;
            end
        end
    end

    // Blink half-period counter and phase, starting in the "on" phase
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else begin
            r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
            r_blink_on  <= w_blink_on_next;
        end
    end

    // Select the upcoming digit's inputs and test whether it and all higher digits are zero
    always_comb begin
        w_sel_nibble     = '0;
        w_sel_dp         = 1'b0;
        w_sel_blink      = 1'b0;
        w_sel_upper_zero = 1'b1;
        for (int k = 0; k < DIGIT_NUM; k++) begin
            if (r_digit == c_IDX_W'(k)) begin
                w_sel_nibble = i_BCD_Num[4*k +: 4];
                w_sel_dp     = i_DP[k];
                w_sel_blink  = i_Blink_Mask[k];
            end
            if ((c_IDX_W'(k) >= r_digit) && (i_BCD_Num[4*k +: 4] != 4'h0)) begin
                w_sel_upper_zero = 1'b0;
            end
        end
    end

    assign w_suppress = i_Blank_Zeros && (r_digit != '0) && w_sel_upper_zero;

    // Per-slot latch; the blink decision uses the phase in force after this edge
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_slot_valid    <= 1'b0;
            r_cur_digit     <= '0;
            r_lat_nibble    <= '0;
            r_lat_dp        <= 1'b0;
            r_lat_blink_off <= 1'b0;
            r_lat_suppress  <= 1'b0;
        end else if (w_slot_wrap) begin
            r_slot_valid    <= 1'b1;
            r_cur_digit     <= r_digit;
            r_lat_nibble    <= w_sel_nibble;
            r_lat_dp        <= w_sel_dp;
            r_lat_blink_off <= w_sel_blink && !w_blink_on_next;
            r_lat_suppress  <= w_suppress;
        end
    end

    seven_segment_encoder u_encoder (
        .i_nibble  (r_lat_nibble),
        .o_pattern (w_pattern)
    );

    assign w_seg   = (r_slot_valid && !r_lat_suppress) ? w_pattern : c_SEG_BLANK;
    assign w_dp    = r_slot_valid && r_lat_dp;
    assign w_an_on = i_Enable && r_slot_valid && (r_phase <= i_Brightness) && !r_lat_blink_off;

    // One-hot anode for the digit currently on display
    always_comb begin
        w_an = '0;
        for (int k = 0; k < DIGIT_NUM; k++) begin
            w_an[k] = w_an_on && (r_cur_digit == c_IDX_W'(k));
        end
    end

    // Output registers with pin polarity applied
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_Anodes      <= c_AN_OFF;
            o_Segments    <= c_SEG_OFF;
            o_DP          <= c_DP_OFF;
            o_Frame_Start <= 1'b0;
        end else begin
            o_Anodes      <= (ACTIVE_LOW_AN  != 0) ? ~w_an  : w_an;
            o_Segments    <= (ACTIVE_LOW_SEG != 0) ? ~w_seg : w_seg;
            o_DP          <= (ACTIVE_LOW_SEG != 0) ? ~w_dp  : w_dp;
            o_Frame_Start <= r_slot_valid && (r_slot_cnt == '0) && (r_cur_digit == '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_segment_scan_controller
//  Description : Directed self-checking bench, TICKS=16, SUB=1, HB=32,
//                four digits, active-low pins. Slot j (digit j mod 4) is
//                visible after clock edges 16j+17 .. 16j+32 counted from
//                reset release.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_scan_controller;

    logic        i_Clk = 1'b0;
    logic        i_Reset_n = 1'b0;
    logic        i_Enable = 1'b1;
    logic [15:0] i_BCD_Num = 16'h1234;
    logic [3:0]  i_DP = 4'b0000;
    logic [3:0]  i_Blink_Mask = 4'b0000;
    logic        i_Blank_Zeros = 1'b0;
    logic [3:0]  i_Brightness = 4'd15;
    logic [6:0]  o_Segments;
    logic        o_DP;
    logic [3:0]  o_Anodes;
    logic        o_Frame_Start;

    // Inverted (active-low) patterns
    localparam logic [6:0] c_S0   = 7'h40;
    localparam logic [6:0] c_S1   = 7'h79;
    localparam logic [6:0] c_S2   = 7'h24;
    localparam logic [6:0] c_S3   = 7'h30;
    localparam logic [6:0] c_S4   = 7'h19;
    localparam logic [6:0] c_S5   = 7'h12;
    localparam logic [6:0] c_DASH = 7'h3F;
    localparam logic [6:0] c_OFF  = 7'h7F;

    int n_compared   = 0;
    int n_mismatched = 0;
    int edge_cnt     = 0;
    int n_tmp        = 0;

    seven_segment_scan_controller #(
        .CLK_IN         (1600),
        .DIGIT_NUM      (4),
        .REFRESH_HZ     (100),
        .BLINK_HZ       (25),
        .ACTIVE_LOW_SEG (1),
        .ACTIVE_LOW_AN  (1)
    ) u_dut (
        .i_Clk         (i_Clk),
        .i_Reset_n     (i_Reset_n),
        .i_Enable      (i_Enable),
        .i_BCD_Num     (i_BCD_Num),
        .i_DP          (i_DP),
        .i_Blink_Mask  (i_Blink_Mask),
        .i_Blank_Zeros (i_Blank_Zeros),
        .i_Brightness  (i_Brightness),
        .o_Segments    (o_Segments),
        .o_DP          (o_DP),
        .o_Anodes      (o_Anodes),
        .o_Frame_Start (o_Frame_Start)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge and park on the following falling edge
    task automatic tick();
        @(posedge i_Clk);
        edge_cnt++;
        @(negedge i_Clk);
    endtask

    task automatic goto_edge(input int e);
        while (edge_cnt < e) tick();
    endtask

    function automatic int slot_edge(input int j, input int q);
        return 16 * j + 17 + q;
    endfunction

    task automatic restart();
        @(negedge i_Clk);
        i_Reset_n = 1'b0;
        repeat (2) @(negedge i_Clk);
        i_Reset_n = 1'b1;
        edge_cnt  = 0;
    endtask

    task automatic count_active(input int j, output int n);
        n = 0;
        for (int q = 0; q < 16; q++) begin
            goto_edge(slot_edge(j, q));
            if (o_Anodes != 4'hF) n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(negedge i_Clk);
        check_val("rst_anodes", 32'(o_Anodes), 32'hF);
        check_val("rst_segments", 32'(o_Segments), 32'(c_OFF));
        check_val("rst_dp", 32'(o_DP), 32'h1);
        check_val("rst_frame", 32'(o_Frame_Start), 32'h0);
        i_Reset_n = 1'b1;
        edge_cnt  = 0;

        // ---------------- basic scan 1234 ----------------
        goto_edge(8);
        check_val("preslot_anodes", 32'(o_Anodes), 32'hF);
        goto_edge(16);
        check_val("preslot_frame", 32'(o_Frame_Start), 32'h0);
        goto_edge(slot_edge(0, 0));
        check_val("scan_d0_an", 32'(o_Anodes), 32'hE);
        check_val("scan_d0_seg", 32'(o_Segments), 32'(c_S4));
        check_val("scan_frame_first", 32'(o_Frame_Start), 32'h1);
        goto_edge(slot_edge(0, 1));
        check_val("scan_frame_pulse_len", 32'(o_Frame_Start), 32'h0);
        goto_edge(slot_edge(0, 15));
        check_val("scan_d0_an_end", 32'(o_Anodes), 32'hE);
        goto_edge(slot_edge(1, 0));
        check_val("scan_d1_an", 32'(o_Anodes), 32'hD);
        check_val("scan_d1_seg", 32'(o_Segments), 32'(c_S3));
        goto_edge(slot_edge(2, 0));
        check_val("scan_d2_an", 32'(o_Anodes), 32'hB);
        check_val("scan_d2_seg", 32'(o_Segments), 32'(c_S2));
        goto_edge(slot_edge(3, 0));
        check_val("scan_d3_an", 32'(o_Anodes), 32'h7);
        check_val("scan_d3_seg", 32'(o_Segments), 32'(c_S1));
        n_tmp = 0;
        for (int e = slot_edge(3, 1); e <= slot_edge(4, 0); e++) begin
            goto_edge(e);
            if (o_Frame_Start) n_tmp++;
        end
        check_val("scan_frame_per_64", 32'(n_tmp), 32'd1);
        check_val("scan_frame_at_64", 32'(o_Frame_Start), 32'h1);

        // ---------------- leading-zero suppression ----------------
        i_BCD_Num = 16'h0050; i_Blank_Zeros = 1'b1;
        restart();
        goto_edge(slot_edge(0, 0));
        check_val("sup_d0_seg", 32'(o_Segments), 32'(c_S0));
        goto_edge(slot_edge(1, 0));
        check_val("sup_d1_seg", 32'(o_Segments), 32'(c_S5));
        goto_edge(slot_edge(2, 0));
        check_val("sup_d2_seg", 32'(o_Segments), 32'(c_OFF));
        check_val("sup_d2_an", 32'(o_Anodes), 32'hB);
        goto_edge(slot_edge(3, 0));
        check_val("sup_d3_seg", 32'(o_Segments), 32'(c_OFF));
        i_BCD_Num = 16'h0000;
        restart();
        goto_edge(slot_edge(0, 0));
        check_val("sup0_d0_seg", 32'(o_Segments), 32'(c_S0));
        goto_edge(slot_edge(1, 0));
        check_val("sup0_d1_seg", 32'(o_Segments), 32'(c_OFF));
        i_BCD_Num = 16'h0050; i_Blank_Zeros = 1'b0;
        restart();
        goto_edge(slot_edge(3, 0));
        check_val("nosup_d3_seg", 32'(o_Segments), 32'(c_S0));

        // ---------------- brightness ----------------
        i_BCD_Num = 16'h1234; i_Brightness = 4'd3;
        restart();
        count_active(0, n_tmp);
        check_val("bright3_count", 32'(n_tmp), 32'd4);
        goto_edge(slot_edge(1, 3));
        check_val("bright3_p3_an", 32'(o_Anodes), 32'hD);
        goto_edge(slot_edge(1, 5));
        check_val("bright3_p5_an", 32'(o_Anodes), 32'hF);
        i_Brightness = 4'd15;
        goto_edge(slot_edge(1, 6));
        check_val("bright_latency_an", 32'(o_Anodes), 32'hD);
        i_Brightness = 4'd0;
        count_active(2, n_tmp);
        check_val("bright0_count", 32'(n_tmp), 32'd1);
        i_Brightness = 4'd15;

        // ---------------- blink ----------------
        i_Blink_Mask = 4'b0010;
        restart();
        goto_edge(slot_edge(0, 0));
        check_val("blink_d0_an", 32'(o_Anodes), 32'hE);
        goto_edge(slot_edge(1, 0));
        check_val("blink_d1_an", 32'(o_Anodes), 32'hF);
        goto_edge(slot_edge(1, 8));
        check_val("blink_d1_mid_an", 32'(o_Anodes), 32'hF);
        goto_edge(slot_edge(2, 0));
        check_val("blink_d2_an", 32'(o_Anodes), 32'hB);
        goto_edge(slot_edge(4, 0));
        check_val("blink_d0_f2_an", 32'(o_Anodes), 32'hE);
        goto_edge(slot_edge(5, 0));
        check_val("blink_d1_f2_an", 32'(o_Anodes), 32'hF);
        i_Blink_Mask = 4'b1111;
        restart();
        goto_edge(slot_edge(2, 0));
        check_val("blinkall_d2_an", 32'(o_Anodes), 32'hF);
        goto_edge(slot_edge(3, 0));
        check_val("blinkall_d3_an", 32'(o_Anodes), 32'h7);
        i_Blink_Mask = 4'b0000;

        // ---------------- invalid BCD, DP, enable ----------------
        i_BCD_Num = 16'h00C0; i_DP = 4'b0100;
        restart();
        goto_edge(slot_edge(0, 0));
        check_val("dp_d0", 32'(o_DP), 32'h1);
        goto_edge(slot_edge(1, 0));
        check_val("dash_d1_seg", 32'(o_Segments), 32'(c_DASH));
        check_val("dp_d1", 32'(o_DP), 32'h1);
        goto_edge(slot_edge(2, 0));
        check_val("dp_d2", 32'(o_DP), 32'h0);
        goto_edge(slot_edge(3, 0));
        check_val("dp_d3", 32'(o_DP), 32'h1);
        goto_edge(slot_edge(3, 5));
        check_val("en_before_an", 32'(o_Anodes), 32'h7);
        i_Enable = 1'b0;
        goto_edge(slot_edge(3, 6));
        check_val("en_off_an", 32'(o_Anodes), 32'hF);
        goto_edge(slot_edge(4, 0));
        check_val("en_off_next_slot_an", 32'(o_Anodes), 32'hF);
        i_Enable = 1'b1;

        // ---------------- reset mid-slot ----------------
        i_BCD_Num = 16'h1234; i_DP = 4'b0010;
        restart();
        goto_edge(37);
        check_val("prerst_an", 32'(o_Anodes), 32'hD);
        check_val("prerst_dp", 32'(o_DP), 32'h0);
        #2;
        i_Reset_n = 1'b0;
        #1;
        check_val("midrst_an", 32'(o_Anodes), 32'hF);
        check_val("midrst_seg", 32'(o_Segments), 32'(c_OFF));
        check_val("midrst_dp", 32'(o_DP), 32'h1);
        repeat (2) @(negedge i_Clk);
        i_Reset_n = 1'b1;
        edge_cnt  = 0;
        goto_edge(16);
        check_val("postrst_e16_frame", 32'(o_Frame_Start), 32'h0);
        check_val("postrst_e16_an", 32'(o_Anodes), 32'hF);
        goto_edge(17);
        check_val("postrst_e17_frame", 32'(o_Frame_Start), 32'h1);
        check_val("postrst_e17_an", 32'(o_Anodes), 32'hE);
        check_val("postrst_e17_seg", 32'(o_Segments), 32'(c_S4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
